// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory port: word loads/stores served from an
// internal RAM after a fixed LATENCY, with a stall toward the datapath while busy.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic             wr_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic [31:0]      ram [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic [31:0]      look_addr;
    logic             look_wr;
    logic             look_err;
    logic [IDX_W-1:0] look_idx;
    logic             ram_we;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= END_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // With LATENCY=1 the response is built on the acceptance edge itself, so the
    // request is looked at directly; otherwise the captured copy is used.
    assign look_addr = (state == IDLE) ? req_addr  : addr_q;
    assign look_wr   = (state == IDLE) ? req_write : wr_q;
    assign look_err  = addr_bad(look_addr);
    assign look_idx  = addr_idx(look_addr);

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_next == RESP);
    assign ram_we     = (state == RESP) && wr_q && !look_err && !reset;
    assign stall      = req_valid && !resp_valid;

    // NOTE: every output of a combinational block gets a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        count_next = count;
        req_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    count_next = CNT_W'(LATENCY - 1);
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                count_next = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            resp_valid <= enter_resp;
            resp_err   <= enter_resp && look_err;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                if (look_err) begin
                    resp_rdata <= '0;
                end else if (!look_wr) begin
                    resp_rdata <= ram[look_idx];
                end
            end
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset and the block
    // stays mappable onto memory macros. Writes commit on the edge ending RESP.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[look_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 1) against a transaction-level
// model, plus directed sequences with literal expectations.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 1;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  rv;
    logic [1:0]  rw;
    logic [31:0] ra  [2];
    logic [31:0] rwd [2];

    logic        req_ready0, resp_valid0, resp_err0, stall0;
    logic        req_ready1, resp_valid1, resp_err1, stall1;
    logic [31:0] resp_rdata0, resp_rdata1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT0)) u_lat2 (
        .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ready(req_ready0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .stall(stall0)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT1)) u_lat1 (
        .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ready(req_ready1),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .stall(stall1)
    );

    function automatic logic dut_ready(input int d);
        return (d == 0) ? req_ready0 : req_ready1;
    endfunction
    function automatic logic dut_valid(input int d);
        return (d == 0) ? resp_valid0 : resp_valid1;
    endfunction
    function automatic logic dut_err(input int d);
        return (d == 0) ? resp_err0 : resp_err1;
    endfunction
    function automatic logic dut_stall(input int d);
        return (d == 0) ? stall0 : stall1;
    endfunction
    function automatic logic [31:0] dut_rdata(input int d);
        return (d == 0) ? resp_rdata0 : resp_rdata1;
    endfunction
    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit bad_addr(input logic [31:0] a);
        longint unsigned x;
        x = {32'b0, a};
        return (a[1:0] != 2'b00) || (x < {32'b0, BASE}) || (x >= {32'b0, BASE} + 4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2) & (DEPTH - 1);
    endfunction

    int unsigned cyc = 0;
    bit          p_pend  [2];
    int unsigned p_due   [2];
    bit          p_wr    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [31:0] m_rdata [2];
    bit          m_known [2];
    logic [31:0] mref    [2][DEPTH];
    bit          mknown  [2][DEPTH];
    bit          chk_on = 1'b0;

    // A request accepted in cycle c responds in cycle c+LATENCY; a store lands
    // in memory at the end of its response cycle.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                p_pend[d]  = 1'b0;
                m_rdata[d] = '0;
                m_known[d] = 1'b1;
            end else if (p_pend[d] && p_due[d] == cyc) begin
                if (p_wr[d] && !bad_addr(p_addr[d])) begin
                    mref[d][widx(p_addr[d])]   = p_wdata[d];
                    mknown[d][widx(p_addr[d])] = 1'b1;
                end
                p_pend[d] = 1'b0;
            end else if (!p_pend[d] && rv[d]) begin
                p_pend[d]  = 1'b1;
                p_due[d]   = cyc + lat_of(d);
                p_wr[d]    = rw[d];
                p_addr[d]  = ra[d];
                p_wdata[d] = rwd[d];
            end
            if (!rst[d] && p_pend[d] && p_due[d] == cyc + 1) begin
                if (bad_addr(p_addr[d])) begin
                    m_rdata[d] = '0;
                    m_known[d] = 1'b1;
                end else if (!p_wr[d]) begin
                    m_rdata[d] = mref[d][widx(p_addr[d])];
                    m_known[d] = mknown[d][widx(p_addr[d])];
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                bit ev;
                ev = p_pend[d] && (p_due[d] == cyc);
                check("req_ready", d, 32'(dut_ready(d)), 32'(!p_pend[d]));
                check("resp_valid", d, 32'(dut_valid(d)), 32'(ev));
                check("resp_err", d, 32'(dut_err(d)), 32'(ev && bad_addr(p_addr[d])));
                check("stall", d, 32'(dut_stall(d)), 32'(rv[d] && !ev));
                if (m_known[d]) check("resp_rdata", d, dut_rdata(d), m_rdata[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issue one request from idle and hold req_valid until the response; the
    // request fields are scrambled after acceptance and must be ignored.
    task automatic txn(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output bit er);
        int lat;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        @(posedge clk); #1;
        rv[d] = 1'b1; rw[d] = wr; ra[d] = a; rwd[d] = wd;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (dut_valid(d)) begin
                lat = n;
                rd  = dut_rdata(d);
                er  = dut_err(d);
                check("stall in resp cycle", d, 32'(dut_stall(d)), 32'd0);
                break;
            end
            check("stall while waiting", d, 32'(dut_stall(d)), 32'd1);
            @(posedge clk); #1;
            ra[d]  = $urandom;
            rwd[d] = $urandom;
            rw[d]  = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        rv[d] = 1'b0;
        check("latency", d, 32'(lat), 32'(lat_of(d)));
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return BASE + 32'(4 * $urandom_range(0, 7));
            6:       return BASE + 32'(4 * $urandom_range(DEPTH - 8, DEPTH - 1));
            7:       return BASE + 32'($urandom_range(0, 31) | 1);
            8:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            default: return BASE - 32'(4 * $urandom_range(1, 4));
        endcase
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          er;

        rst = 2'b11; rv = 2'b00; rw = 2'b00;
        for (int d = 0; d < 2; d++) begin
            ra[d]  = '0;
            rwd[d] = '0;
        end
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        rst = 2'b00;

        // Idle after reset
        repeat (4) begin
            @(negedge clk);
            check("idle ready", 0, 32'(req_ready0), 32'd1);
            check("idle valid", 0, 32'(resp_valid0), 32'd0);
            check("idle rdata", 0, resp_rdata0, 32'd0);
            check("idle stall", 0, 32'(stall0), 32'd0);
        end

        // Store then load, LATENCY 2
        txn(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, rd, er);
        check("store err", 0, 32'(er), 32'd0);
        txn(0, 1'b0, 32'h1001_0008, 32'h0, rd, er);
        check("load rdata", 0, rd, 32'hDEAD_BEEF);
        check("load err", 0, 32'(er), 32'd0);

        // Misaligned and out-of-range loads
        txn(0, 1'b1, 32'h1001_0000, 32'h0BAD_F00D, rd, er);
        txn(0, 1'b0, 32'h1001_0002, 32'h0, rd, er);
        check("misaligned err", 0, 32'(er), 32'd1);
        check("misaligned rdata", 0, rd, 32'd0);
        txn(0, 1'b0, 32'h1001_1000, 32'h0, rd, er);
        check("out of range err", 0, 32'(er), 32'd1);
        check("out of range rdata", 0, rd, 32'd0);
        txn(0, 1'b0, 32'h1001_0000, 32'h0, rd, er);
        check("word0 intact", 0, rd, 32'h0BAD_F00D);

        // Reset during BUSY discards a store
        txn(0, 1'b1, 32'h1001_0010, 32'hA5A5_0010, rd, er);
        @(posedge clk); #1;
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h1001_0010; rwd[0] = 32'h1234_5678;
        @(posedge clk); #1;
        rst[0] = 1'b1; rv[0] = 1'b0;
        @(negedge clk);
        check("abort no resp", 0, 32'(resp_valid0), 32'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort no resp", 0, 32'(resp_valid0), 32'd0);
            check("abort idle", 0, 32'(req_ready0), 32'd1);
        end
        txn(0, 1'b0, 32'h1001_0010, 32'h0, rd, er);
        check("aborted store absent", 0, rd, 32'hA5A5_0010);

        // LATENCY 1, req_valid held high
        txn(1, 1'b1, 32'h1001_0008, 32'h5555_AAAA, rd, er);
        @(posedge clk); #1;
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h1001_0008; rwd[1] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b valid", 1, 32'(resp_valid1), 32'(i % 2));
            check("b2b ready", 1, 32'(req_ready1), 32'((i + 1) % 2));
            if (i % 2 == 1) check("b2b rdata", 1, resp_rdata1, 32'h5555_AAAA);
        end
        @(posedge clk); #1;
        rv[1] = 1'b0;

        // Last word and just past the end
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h1001_0000, 32'h600D_0000 + 32'(d), rd, er);
            txn(d, 1'b1, 32'h1001_0FFC, 32'hCAFE_0FFC, rd, er);
            check("last word store err", d, 32'(er), 32'd0);
            txn(d, 1'b0, 32'h1001_0FFC, 32'h0, rd, er);
            check("last word rdata", d, rd, 32'hCAFE_0FFC);
            txn(d, 1'b1, 32'h1001_1000, 32'hFFFF_FFFF, rd, er);
            check("past end err", d, 32'(er), 32'd1);
            txn(d, 1'b0, 32'h1001_0000, 32'h0, rd, er);
            check("no alias write", d, rd, 32'h600D_0000 + 32'(d));
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                rv[d]  = ($urandom_range(0, 3) != 0);
                rw[d]  = 1'($urandom_range(0, 1));
                ra[d]  = rand_addr();
                rwd[d] = $urandom;
                rst[d] = ($urandom_range(0, 63) == 0);
            end
        end
        @(posedge clk); #1;
        rst = 2'b00; rv = 2'b00;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
